// File: rtl/tc1_responder_if.sv
// Pin bundle for the TC1 responder: SPI slave pins, host snapshot-load port and frame status.
// The responder uses the slave view; the SPI master and host logic use the master view.
interface tc1_responder_if;
  logic        SCLK;
  logic        CS;
  logic        MISO;
  logic        miso_oe;
  logic        load;
  logic [13:0] temp_termoc;
  logic [11:0] temp_internal;
  logic [2:0]  status;
  logic        busy;
  logic        frame_done;
  logic        frame_abort;

  modport slave (
    input  SCLK, CS, load, temp_termoc, temp_internal, status,
    output MISO, miso_oe, busy, frame_done, frame_abort
  );

  modport master (
    output SCLK, CS, load, temp_termoc, temp_internal, status,
    input  MISO, miso_oe, busy, frame_done, frame_abort
  );
endinterface

// File: rtl/tc1_responder.sv
// Pmod TC1 (MAX31855-style) SPI read-only slave emulator serving a host-loaded 32-bit snapshot.
// Latency: SYNC_STAGES+1 clk from an SCLK/CS edge to action; no backpressure, the SPI master paces it.
module tc1_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  tc1_responder_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } state_t;

  localparam logic [5:0] FRAME_BITS = 6'd32;

  // Synchronisers; CS idles high so its chain resets to 1.
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sync_fill;
  logic                   sclk_d;
  logic                   cs_d;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_rise;
  logic                   cs_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      sync_fill <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      if (SYNC_STAGES > 1) begin
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
        cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.CS};
        sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
      end else begin
        sclk_sync <= bus.SCLK;
        cs_sync   <= bus.CS;
        sync_fill <= '1;
      end
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  // Snapshot layout: termoc, reserved, fault, internal, reserved, {SCV, SCG, OC}.
  logic [31:0] load_word;
  logic [31:0] shadow;

  assign load_word = {bus.temp_termoc, 1'b0, |bus.status, bus.temp_internal, 1'b0, bus.status};

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
    end else if (bus.load) begin
      shadow <= load_word;
    end
  end

  state_t      state;
  logic [31:0] shift_reg;
  logic [5:0]  fall_cnt;
  logic [5:0]  rise_cnt;
  logic        armed;
  logic        miso_q;
  logic        miso_oe_q;
  logic        busy_q;
  logic        frame_done_q;
  logic        frame_abort_q;
  logic [31:0] start_word;

  // A load landing on the same cycle as the CS fall must reach the wire.
  assign start_word = bus.load ? load_word : shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      shift_reg     <= '0;
      fall_cnt      <= '0;
      rise_cnt      <= '0;
      armed         <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      // Only a CS level seen after the synchroniser has flushed its reset value can arm.
      if (sync_fill[SYNC_STAGES-1] && cs_s) begin
        armed <= 1'b1;
      end

      case (state)
        IDLE: begin
          miso_q    <= 1'b0;
          miso_oe_q <= 1'b0;
          busy_q    <= 1'b0;
          if (cs_fall && armed) begin
            shift_reg <= start_word;
            fall_cnt  <= '0;
            rise_cnt  <= '0;
            miso_q    <= start_word[31];
            miso_oe_q <= 1'b1;
            busy_q    <= 1'b1;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            frame_abort_q <= 1'b1;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            busy_q        <= 1'b0;
            state         <= IDLE;
          end else if (sclk_fall) begin
            // Zero fill: shifted-in zeros drive MISO low once all 32 bits are out.
            shift_reg <= {shift_reg[30:0], 1'b0};
            miso_q    <= shift_reg[30];
            if (fall_cnt != FRAME_BITS) begin
              fall_cnt <= fall_cnt + 6'd1;
            end
          end else if (sclk_rise) begin
            if (rise_cnt == FRAME_BITS - 6'd1) begin
              rise_cnt     <= FRAME_BITS;
              frame_done_q <= 1'b1;
              miso_q       <= 1'b0;
              state        <= TAIL;
            end else if (rise_cnt != FRAME_BITS) begin
              rise_cnt <= rise_cnt + 6'd1;
            end
          end
        end

        TAIL: begin
          miso_q <= 1'b0;
          if (cs_rise) begin
            miso_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          miso_q    <= 1'b0;
          miso_oe_q <= 1'b0;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.MISO        = miso_q;
  assign bus.miso_oe     = miso_oe_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_abort = frame_abort_q;

endmodule

// File: tb/tb_tc1_responder.sv
// Bench for tc1_responder: drives SPI frames at SCLK = clk/10 and checks received words against a field-level model.
module tb_tc1_responder;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tc1_responder_if bus();

  tc1_responder #(.SYNC_STAGES(SS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int done_seen   = 0;
  int abort_seen  = 0;

  logic [31:0] shadow_m;

  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) done_seen++;
    if (bus.frame_abort === 1'b1) abort_seen++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Datasheet word: termoc at 31:18, fault at 16, internal at 15:4, status at 2:0.
  function automatic logic [31:0] frame_word(input logic [13:0] t, input logic [11:0] i, input logic [2:0] s);
    logic [31:0] w;
    w = 32'(t) << 18;
    if (s != 3'b000) w = w | 32'h0001_0000;
    w = w | (32'(i) << 4);
    w = w | 32'(s);
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [13:0] t, input logic [11:0] i, input logic [2:0] s);
    bus.temp_termoc   = t;
    bus.temp_internal = i;
    bus.status        = s;
    bus.load          = 1'b1;
    tick(1);
    bus.load          = 1'b0;
    shadow_m          = frame_word(t, i, s);
  endtask

  task automatic run_frame(input string tag, input int nclk, input int load_at,
                           input logic [13:0] nt, input logic [11:0] ni, input logic [2:0] ns);
    logic [31:0] exp_word;
    logic [63:0] rx;
    logic [63:0] exp_rx;
    int d0;
    int a0;
    logic oe_ok;
    exp_word = shadow_m;
    d0 = done_seen;
    a0 = abort_seen;
    rx = '0;
    exp_rx = '0;
    oe_ok = 1'b1;
    bus.CS = 1'b0;
    tick(5);
    for (int k = 0; k < nclk; k++) begin
      rx = {rx[62:0], bus.MISO};
      if (bus.miso_oe !== 1'b1) oe_ok = 1'b0;
      bus.SCLK = 1'b1;
      tick(5);
      bus.SCLK = 1'b0;
      if (k == load_at) begin
        do_load(nt, ni, ns);
        tick(4);
      end else begin
        tick(5);
      end
    end
    for (int k = 0; k < nclk; k++) begin
      exp_rx = {exp_rx[62:0], (k < 32) ? exp_word[31-k] : 1'b0};
    end
    check({tag, "_rx"}, rx, exp_rx);
    check({tag, "_oe"}, 64'(oe_ok), 64'd1);
    check({tag, "_busy_in_frame"}, 64'(bus.busy), 64'd1);
    bus.CS = 1'b1;
    tick(SS);
    check({tag, "_busy_hold"}, 64'(bus.busy), 64'd1);
    tick(1);
    check({tag, "_busy_fall"}, 64'(bus.busy), 64'd0);
    tick(5);
    check({tag, "_done_cnt"}, 64'(done_seen - d0), (nclk >= 32) ? 64'd1 : 64'd0);
    check({tag, "_abort_cnt"}, 64'(abort_seen - a0), (nclk < 32) ? 64'd1 : 64'd0);
    check({tag, "_oe_idle"}, 64'(bus.miso_oe), 64'd0);
  endtask

  initial begin
    logic        quiet_ok;
    logic [13:0] rt;
    logic [11:0] ri;
    logic [2:0]  rs;
    int          lens [5];
    int          nclk;
    int          lat;

    lens = '{8, 16, 24, 32, 36};
    rst = 1'b1;
    bus.SCLK = 1'b0;
    bus.CS = 1'b1;
    bus.load = 1'b0;
    bus.temp_termoc = '0;
    bus.temp_internal = '0;
    bus.status = '0;
    shadow_m = '0;
    tick(3);
    check("rst_miso", 64'(bus.MISO), 64'd0);
    check("rst_oe", 64'(bus.miso_oe), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.frame_done), 64'd0);
    check("rst_abort", 64'(bus.frame_abort), 64'd0);
    rst = 1'b0;
    tick(5);

    do_load(14'h0190, 12'h190, 3'b000);
    check("word_plain", 64'(shadow_m), 64'h0000_0000_0640_1900);
    run_frame("plain", 32, -1, '0, '0, '0);

    do_load(14'h3FFC, 12'h000, 3'b001);
    check("word_fault", 64'(shadow_m), 64'h0000_0000_FFF1_0001);
    run_frame("fault", 32, -1, '0, '0, '0);

    run_frame("abort14", 14, -1, '0, '0, '0);

    do_load(14'h1234, 12'hABC, 3'b000);
    run_frame("midload_f1", 32, 10, 14'h0A5A, 12'h5A5, 3'b100);
    run_frame("midload_f2", 32, -1, '0, '0, '0);

    run_frame("tail40", 40, -1, '0, '0, '0);

    // Reset at bit 10 with CS held low: the block must stay quiet until CS cycles.
    bus.CS = 1'b0;
    tick(5);
    for (int k = 0; k < 10; k++) begin
      bus.SCLK = 1'b1;
      tick(5);
      bus.SCLK = 1'b0;
      tick(5);
    end
    rst = 1'b1;
    tick(2);
    check("midrst_oe", 64'(bus.miso_oe), 64'd0);
    rst = 1'b0;
    shadow_m = '0;
    quiet_ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      bus.SCLK = 1'b1;
      tick(5);
      if (bus.MISO !== 1'b0 || bus.miso_oe !== 1'b0 || bus.busy !== 1'b0) quiet_ok = 1'b0;
      bus.SCLK = 1'b0;
      tick(5);
      if (bus.MISO !== 1'b0 || bus.miso_oe !== 1'b0 || bus.busy !== 1'b0) quiet_ok = 1'b0;
    end
    check("postrst_quiet", 64'(quiet_ok), 64'd1);
    bus.CS = 1'b1;
    tick(8);
    run_frame("postrst", 32, -1, '0, '0, '0);

    for (int it = 0; it < 8; it++) begin
      rt = 14'($urandom);
      ri = 12'($urandom);
      rs = 3'($urandom);
      if ($urandom_range(3, 0) != 0) do_load(rt, ri, rs);
      nclk = lens[$urandom_range(4, 0)];
      lat = ($urandom_range(1, 0) == 1) ? int'($urandom_range(nclk - 2, 2)) : -1;
      rt = 14'($urandom);
      ri = 12'($urandom);
      rs = 3'($urandom);
      run_frame("rand", nclk, lat, rt, ri, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
